irq_sequencer: RTL and testbench

Interrupt controller that sequences the next-PC interrupt path. It latches edge-triggered interrupt requests, masks and prioritises them, and raises `alert` toward the next-PC logic. On the `interrupt` pulse returned by that logic, it captures the return PC, holds `interrupt_mask` high while the handler runs, and releases it on `rti`. It also supplies the handler vector used as the interrupt target PC and exposes a small configuration register port.

---
 rtl/irq_pkg.sv | 9 +
 rtl/irq_prio_enc.sv | 16 +
 rtl/irq_sequencer.sv | 110 +++++++++++
 tb/tb_irq_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared state encoding and configuration register map for the interrupt sequencer.
package irq_pkg;
    typedef enum logic [1:0] {IDLE, ALERT, SERVICE} state_t;
    localparam logic [1:0] EN    = 2'd0;
    localparam logic [1:0] VBASE = 2'd1;
    localparam logic [1:0] PEND  = 2'd2;
    localparam logic [1:0] EPC   = 2'd3;
    localparam int GIE_BIT = 31;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-first priority encoder returning the winning index and a valid flag.
module irq_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (i_req[i]) o_idx = W'(i);
    end
    assign o_valid = |i_req;
endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer: latches edge-triggered IRQs, arbitrates by priority, raises alert to the next-PC logic
// and tracks the handler window between int_taken and rti.
module irq_sequencer
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
    localparam int         IW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [31:0]        pc_in,
    input  logic               int_taken,
    input  logic               rti,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               alert,
    output logic               interrupt_mask,
    output logic [31:0]        int_vector,
    output logic [31:0]        epc,
    output logic [IW-1:0]      int_id
);
    state_t             r_state, w_next;
    logic [NUM_IRQ-1:0] r_irq_q, r_irq_prev, r_pending, r_enable;
    logic               r_gie, r_bad_taken, r_bad_rti;
    logic [31:0]        r_vec_base, r_epc, w_en_word;
    logic [IW-1:0]      r_int_id, w_win;
    logic [NUM_IRQ-1:0] w_set, w_clr, w_eligible;
    logic               w_win_valid, w_take, w_wr_en, w_wr_vb, w_wr_pend;

    irq_prio_enc #(.N(NUM_IRQ), .W(IW)) u_prio (
        .i_req   (w_eligible),
        .o_idx   (w_win),
        .o_valid (w_win_valid)
    );

    assign w_set      = r_irq_q & ~r_irq_prev;
    assign w_eligible = r_pending & r_enable & {NUM_IRQ{r_gie}};
    assign w_take     = int_taken && r_state == ALERT;
    assign w_wr_en    = cfg_we && cfg_addr == EN;
    assign w_wr_vb    = cfg_we && cfg_addr == VBASE;
    assign w_wr_pend  = cfg_we && cfg_addr == PEND;
    // A new edge in the same cycle as a clear keeps the bit set.
    assign w_clr      = (w_wr_pend ? cfg_wdata[NUM_IRQ-1:0] : '0)
                      | (w_take ? NUM_IRQ'(1) << r_int_id : '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_win_valid) w_next = ALERT;
            ALERT:   if (int_taken) w_next = SERVICE;
            SERVICE: if (rti) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_irq_q     <= '0;
            r_irq_prev  <= '0;
            r_pending   <= '0;
            r_enable    <= '0;
            r_gie       <= 1'b0;
            r_vec_base  <= VEC_BASE;
            r_epc       <= '0;
            r_int_id    <= '0;
            r_bad_taken <= 1'b0;
            r_bad_rti   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_irq_q    <= irq_in;
            r_irq_prev <= r_irq_q;
            r_pending  <= (r_pending & ~w_clr) | w_set;
            if (w_wr_en) begin
                r_enable <= cfg_wdata[NUM_IRQ-1:0];
                r_gie    <= cfg_wdata[GIE_BIT];
            end
            if (w_wr_vb) r_vec_base <= {cfg_wdata[31:2], 2'b00};
            if (r_state == IDLE && w_win_valid) r_int_id <= w_win;
            if (w_take) r_epc <= pc_in;
            r_bad_taken <= r_bad_taken | (int_taken && r_state != ALERT);
            r_bad_rti   <= r_bad_rti | (rti && r_state != SERVICE);
        end
    end

    always_comb begin
        w_en_word                  = '0;
        w_en_word[NUM_IRQ-1:0]     = r_enable;
        w_en_word[GIE_BIT]         = r_gie;
    end

    assign cfg_rdata      = cfg_addr == EN    ? w_en_word
                          : cfg_addr == VBASE ? r_vec_base
                          : cfg_addr == PEND  ? 32'(r_pending)
                          : r_epc;
    assign alert          = r_state == ALERT;
    assign interrupt_mask = r_state == SERVICE;
    assign int_vector     = r_vec_base + 32'(r_int_id) * VEC_STRIDE;
    assign epc            = r_epc;
    assign int_id         = r_int_id;

    a_bad_taken_sticky: assert property (@(posedge clk) disable iff (!rst_n) r_bad_taken |=> r_bad_taken);
    a_bad_rti_sticky:   assert property (@(posedge clk) disable iff (!rst_n) r_bad_rti |=> r_bad_rti);
    a_alert_mask_excl:  assert property (@(posedge clk) disable iff (!rst_n) !(alert && interrupt_mask));
endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: scoreboarded random and directed test of irq_sequencer against a behavioural model.
module tb_irq_sequencer;
    localparam int N = 4;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] irq_in = '0;
    logic [31:0] pc_in = '0, cfg_wdata = '0;
    logic        int_taken = 1'b0, rti = 1'b0, cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_rdata, int_vector, epc;
    logic        alert, interrupt_mask;
    logic [1:0]  int_id;
    int n_chk = 0, n_fail = 0;

    typedef struct { int id; logic [31:0] vec; } exp_t;
    exp_t exp_q[$];

    logic [N-1:0] m_pend = '0, m_en = '0;
    logic         m_gie = 1'b0, m_busy = 1'b0, m_handler = 1'b0;
    int           m_id = 0;
    logic [31:0]  m_vbase = 32'h100, m_epc = '0;
    logic         prev_alert = 1'b0;

    always #10 clk = ~clk;

    irq_sequencer #(.NUM_IRQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .pc_in(pc_in),
        .int_taken(int_taken), .rti(rti), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .alert(alert),
        .interrupt_mask(interrupt_mask), .int_vector(int_vector), .epc(epc), .int_id(int_id)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising alert must match the oldest predicted request.
    always @(negedge clk) begin
        exp_t e;
        if (alert && !prev_alert) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_alert: got int_id %0d, expected no alert", int_id);
            end else begin
                e = exp_q.pop_front();
                check("alert_id", 32'(int_id), 32'(e.id));
                check("alert_vector", int_vector, e.vec);
            end
        end
        prev_alert = alert;
    end

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic arm();
        logic [N-1:0] el;
        el = m_pend & m_en & {N{m_gie}};
        if (!m_busy && el != 0) begin
            m_id   = lowest(el);
            m_busy = 1'b1;
            exp_q.push_back(exp_t'{m_id, m_vbase + 32'(m_id) * 32'h10});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] d;
        rd(2'd0, d); check({tag, "_en"}, d, {m_gie, 27'b0, m_en});
        rd(2'd1, d); check({tag, "_vbase"}, d, m_vbase);
        rd(2'd2, d); check({tag, "_pend"}, d, 32'(m_pend));
        rd(2'd3, d); check({tag, "_epc"}, d, m_epc);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick(1);
        cfg_we = 1'b0;
        case (a)
            2'd0: begin m_en = d[N-1:0]; m_gie = d[31]; end
            2'd1: m_vbase = d & ~32'h3;
            2'd2: m_pend = m_pend & ~d[N-1:0];
            default: ;
        endcase
        arm();
    endtask

    task automatic pulse(input logic [N-1:0] m);
        irq_in = m;
        m_pend = m_pend | m;
        arm();
        tick(1);
        irq_in = '0;
        tick(2);
    endtask

    task automatic wait_alert();
        int k = 0;
        while (!alert && k < 10) begin
            tick(1);
            k++;
        end
        check("alert_seen", 32'(alert), 32'd1);
    endtask

    task automatic take(input logic [31:0] pc);
        logic [31:0] d;
        pc_in = pc; int_taken = 1'b1;
        tick(1);
        int_taken = 1'b0;
        if (m_busy && !m_handler) begin
            m_epc = pc;
            m_pend[m_id] = 1'b0;
            m_handler = 1'b1;
        end
        check("epc_after_take", epc, m_epc);
        check("mask_after_take", 32'(interrupt_mask), 32'(m_handler));
        check("alert_after_take", 32'(alert), 32'd0);
        rd(2'd2, d); check("pend_after_take", d, 32'(m_pend));
    endtask

    task automatic do_rti();
        rti = 1'b1;
        tick(1);
        rti = 1'b0;
        m_handler = 1'b0;
        m_busy = 1'b0;
        arm();
        check("mask_after_rti", 32'(interrupt_mask), 32'd0);
        check("alert_after_rti", 32'(alert), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        tick(1);
        check("rst_alert", 32'(alert), 32'd0);
        check("rst_mask", 32'(interrupt_mask), 32'd0);
        check("rst_int_id", 32'(int_id), 32'd0);
        check_regs("rst");
        rst_n = 1'b1;
        tick(1);

        cfg_write(2'd0, 32'h8000_0001);
        irq_in = 4'b0001; m_pend[0] = 1'b1; arm();
        tick(1);
        irq_in = '0;
        rd(2'd2, d); check("t1_pend_c1", d, 32'd0);
        tick(1);
        rd(2'd2, d); check("t1_pend_c2", d, 32'd1);
        check("t1_alert_c2", 32'(alert), 32'd0);
        tick(1);
        check("t1_alert_c3", 32'(alert), 32'd1);
        check("t1_vector", int_vector, 32'h100);
        take(32'h0000_2040);
        check("t1_epc", epc, 32'h2040);
        do_rti();

        cfg_write(2'd0, 32'h8000_000F);
        pulse(4'b0110);
        wait_alert();
        check("t2_vector", int_vector, 32'h110);
        take(32'h3000);
        do_rti();
        wait_alert();
        check("t2_vector2", int_vector, 32'h120);
        take(32'h3004);
        do_rti();

        pulse(4'b1000);
        wait_alert();
        take(32'h4000);
        pulse(4'b0001);
        check("t3_no_alert", 32'(alert), 32'd0);
        check("t3_mask", 32'(interrupt_mask), 32'd1);
        do_rti();
        tick(1);
        check("t3_alert_after_idle", 32'(alert), 32'd1);
        check("t3_id", 32'(int_id), 32'd0);
        take(32'h4100);
        do_rti();

        cfg_write(2'd1, 32'hFFFF_FFF3);
        rd(2'd1, d); check("t4_vbase", d, 32'hFFFF_FFF0);
        pulse(4'b0010);
        wait_alert();
        check("t4_wrap", int_vector, 32'h0);
        take(32'h5000);
        do_rti();
        cfg_write(2'd1, 32'h100);

        cfg_write(2'd0, 32'h0000_0001);
        pulse(4'b0001);
        rd(2'd2, d); check("t5_pend", d, 32'd1);
        check("t5_no_alert", 32'(alert), 32'd0);
        cfg_write(2'd2, 32'd1);
        rd(2'd2, d); check("t5_pend_w1c", d, 32'd0);
        cfg_write(2'd0, 32'h8000_0001);
        tick(3);
        check("t5_gie_no_alert", 32'(alert), 32'd0);

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(3) == 0)
                cfg_write(2'd0, {1'($urandom_range(3) != 0), 27'b0, 4'($urandom)});
            pulse(4'($urandom));
            check_regs("rnd");
            if (m_busy) begin
                wait_alert();
                if ($urandom_range(1) == 1) pulse(4'($urandom));
                take($urandom);
                if ($urandom_range(1) == 1) pulse(4'($urandom));
                check("rnd_mask", 32'(interrupt_mask), 32'd1);
                if ($urandom_range(3) == 0) cfg_write(2'd2, 32'($urandom_range(15)));
                do_rti();
            end
        end
        tick(4);
        if (m_busy) begin
            wait_alert();
            take(32'h6000);
            do_rti();
        end

        cfg_write(2'd0, 32'h8000_000F);
        pulse(4'b0100);
        wait_alert();
        rst_n = 1'b0;
        #1;
        check("t6_alert_async", 32'(alert), 32'd0);
        check("t6_mask_async", 32'(interrupt_mask), 32'd0);
        exp_q.delete();
        m_pend = '0; m_en = '0; m_gie = 1'b0; m_busy = 1'b0; m_handler = 1'b0;
        m_vbase = 32'h100; m_epc = '0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check_regs("t6");
        take(32'h1234);
        do_rti();
        tick(3);
        check("t6_no_alert", 32'(alert), 32'd0);
        check("t6_epc", epc, 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
